// File: rtl/sensor_sample_ctrl.sv
// Periodic sensor sampler: waits for period-counter carry, requests a sample and stores it.
// Define SCTRL_TIMEOUT_EN to add a 256-cycle request timeout with a sticky err flag.
module sensor_sample_ctrl #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    input  logic          cnt_carry,
    output logic          cnt_load,
    output logic          cnt_stop,
    output logic          sensor_req,
    input  logic          sensor_valid,
    input  logic [DW-1:0] sensor_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   wr_cnt,
    output logic          full,
    output logic          interrupt,
    output logic          err
);

    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StReq,
        StFull
    } state_e;

    state_e        state_q, state_d;
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic [AW:0]   wr_cnt_inc;
    logic          interrupt_q, interrupt_d;
    logic [DW-1:0] rd_data_q;
    logic          wr_en;
    logic [DW-1:0] mem [DEPTH];

`ifdef SCTRL_TIMEOUT_EN
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       err_q, err_d;
    logic       timeout;

    assign timeout = (state_q == StReq) && !sensor_valid && (to_cnt_q == 8'hFF);
    assign err     = err_q;
`else
    assign err = 1'b0;
`endif

    assign wr_cnt_inc = wr_cnt_q + (AW+1)'(1);
    assign wr_cnt     = wr_cnt_q;
    assign full       = (wr_cnt_q == FullCnt);
    assign interrupt  = interrupt_q;
    assign rd_data    = rd_data_q;

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        interrupt_d = interrupt_q;
        wr_en       = 1'b0;
        cnt_load    = 1'b0;
        cnt_stop    = 1'b0;
        sensor_req  = 1'b0;
`ifdef SCTRL_TIMEOUT_EN
        err_d    = err_q;
        to_cnt_d = 8'd0;
`endif
        unique case (state_q)
            StIdle: begin
                if (en && !full) begin
                    state_d = StCount;
                end
            end
            StCount: begin
                cnt_load = 1'b1;
                if (!en) begin
                    state_d = StIdle;
                end else if (cnt_carry) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                // en is deliberately ignored until the outstanding request resolves
                sensor_req = 1'b1;
                if (sensor_valid) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_inc;
                    if (wr_cnt_inc == FullCnt) begin
                        state_d     = StFull;
                        interrupt_d = 1'b1;
                    end else if (en) begin
                        state_d = StCount;
                    end else begin
                        state_d = StIdle;
                    end
                end
`ifdef SCTRL_TIMEOUT_EN
                else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = en ? StCount : StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
`endif
            end
            StFull: begin
                cnt_stop = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // clear overrides everything, including a sample arriving this cycle
        if (clear) begin
            state_d     = StIdle;
            wr_cnt_d    = '0;
            interrupt_d = 1'b0;
            wr_en       = 1'b0;
`ifdef SCTRL_TIMEOUT_EN
            err_d    = 1'b0;
            to_cnt_d = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_cnt_q    <= '0;
            interrupt_q <= 1'b0;
            rd_data_q   <= '0;
`ifdef SCTRL_TIMEOUT_EN
            err_q    <= 1'b0;
            to_cnt_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            interrupt_q <= interrupt_d;
            rd_data_q   <= mem[rd_addr];
`ifdef SCTRL_TIMEOUT_EN
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    // Buffer storage is intentionally not reset; contents survive clear and rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt_q[AW-1:0]] <= sensor_data;
        end
    end

endmodule

// File: tb/tb_sensor_sample_ctrl.sv
// Scoreboard bench for sensor_sample_ctrl: stimulus pushes expected buffer count and read data,
// a monitor pops and compares whenever wr_cnt moves or a registered read completes.
module tb_sensor_sample_ctrl;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          clear = 1'b0;
    logic          cnt_carry = 1'b0;
    logic          sensor_valid = 1'b0;
    logic [DW-1:0] sensor_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          cnt_load, cnt_stop, sensor_req, full, interrupt, err;
    logic [DW-1:0] rd_data;
    logic [AW:0]   wr_cnt;

    int total = 0;
    int bad = 0;

    // reference model: buffer image, which entries were ever written, sample count
    logic [DW-1:0] model_mem [DEPTH];
    bit            model_known [DEPTH];
    int            model_cnt = 0;

    int            exp_wr_q[$];
    logic [DW-1:0] exp_rd_q[$];
    bit            rd_chk = 1'b0;
    int            last_wr = 0;
    bit            fire;

    always #5 clk = ~clk;

    sensor_sample_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clear        (clear),
        .cnt_carry    (cnt_carry),
        .cnt_load     (cnt_load),
        .cnt_stop     (cnt_stop),
        .sensor_req   (sensor_req),
        .sensor_valid (sensor_valid),
        .sensor_data  (sensor_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wr_cnt       (wr_cnt),
        .full         (full),
        .interrupt    (interrupt),
        .err          (err)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input int a);
        rd_addr = AW'(a);
        rd_chk  = 1'b1;
        exp_rd_q.push_back(model_mem[a]);
        tick();
        rd_chk = 1'b0;
    endtask

    // One carry/request/valid sequence starting from COUNT with en=1.
    task automatic do_sample(input logic [DW-1:0] data, input int gap, input bit drop_en,
                             input bit spurious, input bit rd_same);
        if (spurious) begin
            sensor_valid = 1'b1;
            sensor_data  = ~data;
            tick();
            sensor_valid = 1'b0;
        end
        if (model_cnt < DEPTH) check("cnt_load_count", cnt_load, 1);
        cnt_carry = 1'b1;
        tick();
        cnt_carry = 1'b0;
        if (model_cnt >= DEPTH) begin
            check("no_req_when_full", sensor_req, 0);
            return;
        end
        check("sensor_req_start", sensor_req, 1);
        if (drop_en) en = 1'b0;
        repeat (gap) tick();
        check("sensor_req_hold", sensor_req, 1);
        sensor_valid = 1'b1;
        sensor_data  = data;
        if (rd_same && model_known[model_cnt]) begin
            rd_addr = AW'(model_cnt);
            rd_chk  = 1'b1;
            exp_rd_q.push_back(model_mem[model_cnt]);
        end
        model_mem[model_cnt]   = data;
        model_known[model_cnt] = 1'b1;
        model_cnt++;
        exp_wr_q.push_back(model_cnt);
        tick();
        sensor_valid = 1'b0;
        rd_chk       = 1'b0;
        check("sensor_req_done", sensor_req, 0);
        if (model_cnt == DEPTH) begin
            check("full_set", full, 1);
            check("irq_set", interrupt, 1);
            check("cnt_stop_full", cnt_stop, 1);
            check("cnt_load_full", cnt_load, 0);
            en = 1'b1;
        end else if (drop_en) begin
            check("cnt_load_idle", cnt_load, 0);
            en = 1'b1;
            tick();
        end else begin
            check("cnt_load_back", cnt_load, 1);
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            fire = rd_chk;
            @(negedge clk);
            if (fire) begin
                if (exp_rd_q.size() == 0) begin
                    bad++;
                    total++;
                    $display("FAIL rd_unexpected: got=%0h exp=none", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_rd_q.pop_front());
                end
            end
            if (int'(wr_cnt) != last_wr) begin
                if (exp_wr_q.size() == 0) begin
                    bad++;
                    total++;
                    $display("FAIL wr_cnt_unexpected: got=%0d exp=%0d", wr_cnt, last_wr);
                end else begin
                    check("wr_cnt", wr_cnt, exp_wr_q.pop_front());
                end
                last_wr = int'(wr_cnt);
            end
        end
    end

    initial begin : stim
        int            pa;
        logic [DW-1:0] d;
        #1 rst = 1'b1;
        #2;
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_full", full, 0);
        check("rst_irq", interrupt, 0);
        check("rst_err", err, 0);
        check("rst_cnt_load", cnt_load, 0);
        check("rst_cnt_stop", cnt_stop, 0);
        check("rst_req", sensor_req, 0);
        check("rst_rd_data", rd_data, 0);
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b1;
        tick();

        do_sample(32'hA5A5_0001, 1, 1'b0, 1'b0, 1'b0);
        issue_read(0);

        while (model_cnt < DEPTH) begin
            int g;
            bit drop;
            g    = (model_cnt == 5) ? 3 : int'($urandom_range(0, 3));
            drop = (model_cnt == 5) || ($urandom_range(0, 7) == 0);
            d    = $urandom;
            do_sample(d, g, drop, $urandom_range(0, 5) == 0, 1'b0);
        end
        check("wr_cnt_at_full", wr_cnt, DEPTH);

        do_sample(32'h0BAD_0BAD, 0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        check("full_no_req", sensor_req, 0);
        check("full_irq_hold", interrupt, 1);

        for (int a = 0; a < DEPTH; a++) issue_read(a);

        clear = 1'b1;
        model_cnt = 0;
        exp_wr_q.push_back(0);
        tick();
        clear = 1'b0;
        check("clr_irq", interrupt, 0);
        check("clr_full", full, 0);
        check("clr_cnt_stop", cnt_stop, 0);
        check("clr_idle", cnt_load, 0);
        tick();
        d = $urandom;
        do_sample(d, 1, 1'b0, 1'b0, 1'b1);
        issue_read(0);
        issue_read(1);

        cnt_carry = 1'b1;
        tick();
        cnt_carry = 1'b0;
        check("req_before_clr", sensor_req, 1);
        clear        = 1'b1;
        sensor_valid = 1'b1;
        sensor_data  = 32'hDEAD_BEEF;
        model_cnt    = 0;
        exp_wr_q.push_back(0);
        tick();
        clear        = 1'b0;
        sensor_valid = 1'b0;
        check("clr_req_drop", sensor_req, 0);
        check("clr_req_idle", cnt_load, 0);
        issue_read(0);

        cnt_carry = 1'b1;
        tick();
        cnt_carry = 1'b0;
        repeat (255) tick();
        check("to_req_255", sensor_req, 1);
        check("to_err_255", err, 0);
        tick();
`ifdef SCTRL_TIMEOUT_EN
        check("to_err_set", err, 1);
        check("to_count", cnt_load, 1);
        check("to_req_drop", sensor_req, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("to_err_clr", err, 0);
        tick();
`else
        check("no_to_req", sensor_req, 1);
        check("no_to_err", err, 0);
        sensor_valid = 1'b1;
        d            = $urandom;
        sensor_data  = d;
        model_mem[model_cnt] = d;
        model_cnt++;
        exp_wr_q.push_back(model_cnt);
        tick();
        sensor_valid = 1'b0;
        check("no_to_back", cnt_load, 1);
`endif

        repeat (3) begin
            d = $urandom;
            do_sample(d, int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0);
        end
        pa = model_cnt;
        cnt_carry = 1'b1;
        tick();
        cnt_carry = 1'b0;
        sensor_valid = 1'b1;
        sensor_data  = 32'h1234_5678;
        model_cnt    = 0;
        exp_wr_q.push_back(0);
        rst = 1'b1;
        #1;
        check("rst_mid_req", sensor_req, 0);
        check("rst_mid_wr_cnt", wr_cnt, 0);
        check("rst_mid_rd_data", rd_data, 0);
        check("rst_mid_cnt_load", cnt_load, 0);
        tick();
        sensor_valid = 1'b0;
        rst = 1'b0;
        tick();
        issue_read(pa);

        repeat (3) tick();
        check("wr_q_drained", exp_wr_q.size(), 0);
        check("rd_q_drained", exp_rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
